// File: rtl/fp_trigger_receiver_n_if.sv
// Trigger-info word handshake between the trigger receiver and the pulse trigger FIFO.
// A word transfers on the cycle fifo_valid and fifo_ready are both high.
interface fp_trigger_receiver_n_if;
  logic         fifo_valid;
  logic         fifo_ready;
  logic [127:0] fifo_data;

  modport master (output fifo_valid, output fifo_data, input fifo_ready);
  modport slave  (input fifo_valid, input fifo_data, output fifo_ready);
endinterface

// File: rtl/fp_trigger_receiver_n.sv
// Front-panel trigger receiver (async mode): qualifies, measures width, emits a FIFO word,
// tracks per-channel DDR3/AMC13 occupancy and vetoes retriggers during a programmable holdoff.
module fp_trigger_receiver_n #(
  parameter int          NCHAN       = 5,
  parameter int          BURST_W     = 23,
  parameter int          WIDTH_W     = 4,
  parameter int          TS_W        = 44,
  parameter int          TNUM_W      = 24,
  parameter int          HOLD_W      = 16,
  parameter logic [63:0] MEM_BURSTS  = 64'd1 << 23,
  parameter logic [63:0] PAYLOAD_MAX = 64'd1 << 20
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           reset_trig_num,
  input  logic                           reset_trig_timestamp,
  input  logic                           trigger,
  input  logic                           ttc_trigger,
  input  logic                           ttc_acq_ready,
  input  logic                           accept_triggers,
  input  logic                           async_mode,
  input  logic [NCHAN-1:0]               chan_en,
  input  logic [NCHAN*BURST_W-1:0]       burst_count,
  input  logic [BURST_W-1:0]             thres_overflow,
  input  logic [WIDTH_W-1:0]             fp_trig_width,
  input  logic [HOLD_W-1:0]              holdoff,
  input  logic                           readout_done,
  fp_trigger_receiver_n_if.master        fifo,
  output logic                           pulse_trigger,
  output logic [TNUM_W-1:0]              trig_num,
  output logic [NCHAN*(BURST_W+1)-1:0]   stored_bursts,
  output logic [4:0]                     state,
  output logic [31:0]                    overflow_count,
  output logic [31:0]                    veto_count,
  output logic                           almost_full
);

  // One extra bit per channel so a completely full channel (MEM_BURSTS) is representable.
  localparam int SW = BURST_W + 1;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_MEASURE = 5'b00010,
    S_STORE   = 5'b00100,
    S_REARM   = 5'b01000,
    S_HOLDOFF = 5'b10000
  } state_e;

  if (TS_W + TNUM_W + 2 + WIDTH_W > 128) begin : g_bad_word_width
    $error("trigger word fields exceed 128 bits");
  end

  state_e              state_q, state_d;
  logic                pulse_q;
  logic [TNUM_W-1:0]   trig_num_q, trig_num_d, tnum_lat_q;
  logic [TS_W-1:0]     ts_q, ts_lat_q;
  logic [WIDTH_W-1:0]  hi_q, hi_d, win_q, win_d;
  logic                went_lo_q, went_lo_d;
  logic [1:0]          type_q, type_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                trig_prev_q;
  logic [31:0]         ovf_q, veto_q;
  logic [SW-1:0]       stored_q [NCHAN];

  logic                acc, accept, reject, veto_hit;
  logic                ddr3_full, payload_full;
  logic [63:0]         psum;

  assign acc = trigger & async_mode & accept_triggers & ~ttc_trigger & ttc_acq_ready;

  // Occupancy checks in 64-bit arithmetic so no term can wrap.
  always_comb begin
    ddr3_full   = 1'b0;
    almost_full = 1'b0;
    psum        = 64'd4;
    for (int i = 0; i < NCHAN; i++) begin
      logic [63:0] add;
      add = chan_en[i] ? 64'(burst_count[i*BURST_W +: BURST_W]) + 64'd1 : 64'd0;
      if (64'(stored_q[i]) + add > MEM_BURSTS) ddr3_full = 1'b1;
      psum = psum + (64'(stored_q[i]) << 1) + (chan_en[i] ? (add << 1) + 64'd5 : 64'd0);
      if (stored_q[i] > SW'(thres_overflow)) almost_full = 1'b1;
    end
    payload_full = psum > PAYLOAD_MAX;
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    win_d     = win_q;
    went_lo_d = went_lo_q;
    type_d    = type_q;
    hold_d    = hold_q;
    accept    = 1'b0;
    reject    = 1'b0;
    veto_hit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (ddr3_full || payload_full) begin
            reject  = 1'b1;
            state_d = S_REARM;
          end else begin
            accept    = 1'b1;
            hi_d      = WIDTH_W'(1);
            win_d     = WIDTH_W'(1);
            went_lo_d = 1'b0;
            type_d    = 2'b00;
            state_d   = (fp_trig_width == '0) ? S_STORE : S_MEASURE;
          end
        end
      end
      S_MEASURE: begin
        if (win_q == fp_trig_width) begin
          type_d  = !trigger ? 2'b01 : (went_lo_q ? 2'b11 : 2'b10);
          state_d = S_STORE;
        end else begin
          win_d = win_q + WIDTH_W'(1);
          if (trigger) begin
            if (hi_q != '1) hi_d = hi_q + WIDTH_W'(1);
          end else begin
            went_lo_d = 1'b1;
          end
        end
      end
      S_STORE: begin
        if (fifo.fifo_ready) state_d = S_REARM;
      end
      S_REARM: begin
        if (!trigger) begin
          hold_d  = '0;
          state_d = (holdoff != '0) ? S_HOLDOFF : S_IDLE;
        end
      end
      S_HOLDOFF: begin
        veto_hit = trigger & ~trig_prev_q;
        if (hold_q == holdoff - HOLD_W'(1)) state_d = S_IDLE;
        else                                hold_d  = hold_q + HOLD_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    trig_num_d = trig_num_q;
    if (reset_trig_num || readout_done) trig_num_d = '0;
    else if (accept)                    trig_num_d = trig_num_q + TNUM_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pulse_q     <= 1'b0;
      trig_num_q  <= '0;
      tnum_lat_q  <= '0;
      ts_q        <= '0;
      ts_lat_q    <= '0;
      hi_q        <= '0;
      win_q       <= '0;
      went_lo_q   <= 1'b0;
      type_q      <= 2'b00;
      hold_q      <= '0;
      trig_prev_q <= 1'b0;
      ovf_q       <= '0;
      veto_q      <= '0;
      for (int i = 0; i < NCHAN; i++) stored_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= accept;
      trig_num_q  <= trig_num_d;
      hi_q        <= hi_d;
      win_q       <= win_d;
      went_lo_q   <= went_lo_d;
      type_q      <= type_d;
      hold_q      <= hold_d;
      trig_prev_q <= trigger;
      ts_q        <= reset_trig_timestamp ? '0 : ts_q + TS_W'(1);
      if (reset_trig_timestamp) ts_lat_q <= '0;
      else if (accept)          ts_lat_q <= ts_q;
      // The word carries the number as it stands after this trigger's update.
      if (accept) tnum_lat_q <= trig_num_d;
      if (reject && ovf_q != '1)    ovf_q  <= ovf_q + 32'd1;
      if (veto_hit && veto_q != '1) veto_q <= veto_q + 32'd1;
      for (int i = 0; i < NCHAN; i++) begin
        if (readout_done)
          stored_q[i] <= '0;
        else if (pulse_q && chan_en[i])
          stored_q[i] <= stored_q[i] + SW'(burst_count[i*BURST_W +: BURST_W]) + SW'(1);
      end
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_stored_out
    assign stored_bursts[g*SW +: SW] = stored_q[g];
  end

  assign fifo.fifo_valid = (state_q == S_STORE);
  assign fifo.fifo_data  = 128'({hi_q, type_q, tnum_lat_q, ts_lat_q});
  assign pulse_trigger   = pulse_q;
  assign trig_num        = trig_num_q;
  assign state           = state_q;
  assign overflow_count  = ovf_q;
  assign veto_count      = veto_q;

endmodule

// File: tb/tb_fp_trigger_receiver_n.sv
// Directed bench: table of single-trigger transactions plus hand sequences for stall,
// holdoff veto, readout/reset interactions and DDR3 capacity (second instance, relaxed payload limit).
module tb_fp_trigger_receiver_n;
  localparam int NCHAN = 5, BURST_W = 23, SW = 24;
  localparam logic [4:0] S_IDLE = 5'b00001, S_STORE = 5'b00100, S_HOLD = 5'b10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, reset_trig_num = 1'b0, reset_trig_timestamp = 1'b0, trigger = 1'b0;
  logic ttc_trigger = 1'b0, ttc_acq_ready = 1'b1, accept_triggers = 1'b1, async_mode = 1'b1;
  logic readout_done = 1'b0, ready = 1'b1;
  logic [NCHAN-1:0]         chan_en = 5'b00001;
  logic [NCHAN*BURST_W-1:0] burst_count = '0;
  logic [BURST_W-1:0]       thres_overflow = '1;
  logic [3:0]               fp_trig_width = 4'd0;
  logic [15:0]              holdoff = 16'd0;

  logic              pulse_trigger, almost_full, cap_pulse, cap_afull;
  logic [23:0]       trig_num, cap_tnum;
  logic [NCHAN*SW-1:0] stored_bursts, cap_stored;
  logic [4:0]        state, cap_state;
  logic [31:0]       overflow_count, veto_count, cap_ovf, cap_veto;

  fp_trigger_receiver_n_if fifo_if ();
  fp_trigger_receiver_n_if cap_if ();
  assign fifo_if.fifo_ready = ready;
  assign cap_if.fifo_ready  = ready;

  fp_trigger_receiver_n dut (
    .clk(clk), .reset(reset), .reset_trig_num(reset_trig_num),
    .reset_trig_timestamp(reset_trig_timestamp), .trigger(trigger), .ttc_trigger(ttc_trigger),
    .ttc_acq_ready(ttc_acq_ready), .accept_triggers(accept_triggers), .async_mode(async_mode),
    .chan_en(chan_en), .burst_count(burst_count), .thres_overflow(thres_overflow),
    .fp_trig_width(fp_trig_width), .holdoff(holdoff), .readout_done(readout_done),
    .fifo(fifo_if), .pulse_trigger(pulse_trigger), .trig_num(trig_num),
    .stored_bursts(stored_bursts), .state(state), .overflow_count(overflow_count),
    .veto_count(veto_count), .almost_full(almost_full));

  fp_trigger_receiver_n #(.PAYLOAD_MAX(64'd1 << 30)) u_cap (
    .clk(clk), .reset(reset), .reset_trig_num(reset_trig_num),
    .reset_trig_timestamp(reset_trig_timestamp), .trigger(trigger), .ttc_trigger(ttc_trigger),
    .ttc_acq_ready(ttc_acq_ready), .accept_triggers(accept_triggers), .async_mode(async_mode),
    .chan_en(chan_en), .burst_count(burst_count), .thres_overflow(thres_overflow),
    .fp_trig_width(fp_trig_width), .holdoff(holdoff), .readout_done(readout_done),
    .fifo(cap_if), .pulse_trigger(cap_pulse), .trig_num(cap_tnum),
    .stored_bursts(cap_stored), .state(cap_state), .overflow_count(cap_ovf),
    .veto_count(cap_veto), .almost_full(cap_afull));

  int pulse_cnt = 0, word_cnt = 0, cap_pulse_cnt = 0;
  logic [127:0] last_word = '0;
  always @(negedge clk) begin
    if (pulse_trigger) pulse_cnt++;
    if (cap_pulse) cap_pulse_cnt++;
    if (fifo_if.fifo_valid && fifo_if.fifo_ready) begin
      word_cnt++;
      last_word = fifo_if.fifo_data;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    trigger = 1'b0; readout_done = 1'b0; reset_trig_num = 1'b0; reset_trig_timestamp = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  pat;      // trigger level per cycle, bit 0 = acceptance cycle
    logic [3:0]  wid;
    logic [4:0]  en;
    logic [22:0] bc;
    int          blk;      // 1 accept off, 2 ttc_trigger, 3 async off, 4 not ready
    int          exp_pulse;
    int          exp_ovf;
    logic [1:0]  exp_type;
    logic [3:0]  exp_hi;
    logic [23:0] exp_st0;
  } vec_t;

  vec_t vecs [13];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, w0, n;
    logic [127:0] d0, exp_word;
    logic stable;

    vecs[0]  = '{8'b00000011, 4'd4, 5'b00001, 23'd0,      0, 1, 0, 2'b01, 4'd2, 24'd1};
    vecs[1]  = '{8'b00011111, 4'd4, 5'b00001, 23'd0,      0, 1, 0, 2'b10, 4'd4, 24'd1};
    vecs[2]  = '{8'b00011101, 4'd4, 5'b00001, 23'd0,      0, 1, 0, 2'b11, 4'd3, 24'd1};
    vecs[3]  = '{8'b00000001, 4'd0, 5'b00001, 23'd0,      0, 1, 0, 2'b00, 4'd1, 24'd1};
    vecs[4]  = '{8'b00000011, 4'd1, 5'b00001, 23'd3,      0, 1, 0, 2'b10, 4'd1, 24'd4};
    vecs[5]  = '{8'b00000001, 4'd2, 5'b00001, 23'd0,      0, 1, 0, 2'b01, 4'd1, 24'd1};
    vecs[6]  = '{8'b00001011, 4'd3, 5'b00001, 23'd0,      0, 1, 0, 2'b11, 4'd2, 24'd1};
    vecs[7]  = '{8'b00000001, 4'd0, 5'b01111, 23'd131068, 0, 1, 0, 2'b00, 4'd1, 24'd131069};
    vecs[8]  = '{8'b00000001, 4'd0, 5'b01111, 23'd131069, 0, 0, 1, 2'b00, 4'd0, 24'd0};
    vecs[9]  = '{8'b00000001, 4'd0, 5'b00001, 23'd0,      1, 0, 0, 2'b00, 4'd0, 24'd0};
    vecs[10] = '{8'b00000001, 4'd0, 5'b00001, 23'd0,      2, 0, 0, 2'b00, 4'd0, 24'd0};
    vecs[11] = '{8'b00000001, 4'd0, 5'b00001, 23'd0,      3, 0, 0, 2'b00, 4'd0, 24'd0};
    vecs[12] = '{8'b00000001, 4'd0, 5'b00001, 23'd0,      4, 0, 0, 2'b00, 4'd0, 24'd0};

    // Reset state
    do_reset();
    chk("reset_state", state, S_IDLE);
    chk("reset_pulse", pulse_trigger, 1'b0);
    chk("reset_trig_num", trig_num, 24'd0);
    chk("reset_fifo_valid", fifo_if.fifo_valid, 1'b0);
    chk("reset_counters", {overflow_count, veto_count}, 64'd0);
    chk("reset_stored", stored_bursts, '0);
    chk("reset_almost_full", almost_full, 1'b0);

    foreach (vecs[i]) begin
      do_reset();
      fp_trig_width   = vecs[i].wid;
      chan_en         = vecs[i].en;
      burst_count     = {NCHAN{vecs[i].bc}};
      accept_triggers = (vecs[i].blk != 1);
      ttc_trigger     = (vecs[i].blk == 2);
      async_mode      = (vecs[i].blk != 3);
      ttc_acq_ready   = (vecs[i].blk != 4);
      p0 = pulse_cnt; w0 = word_cnt;
      for (int c = 0; c < 30; c++) begin
        trigger = (c < 8) ? vecs[i].pat[c] : 1'b0;
        tick();
      end
      chk($sformatf("v%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_pulse);
      chk($sformatf("v%0d_words", i), word_cnt - w0, vecs[i].exp_pulse);
      chk($sformatf("v%0d_overflow", i), overflow_count, vecs[i].exp_ovf);
      chk($sformatf("v%0d_state", i), state, S_IDLE);
      chk($sformatf("v%0d_stored0", i), stored_bursts[SW-1:0], vecs[i].exp_st0);
      chk($sformatf("v%0d_trig_num", i), trig_num, vecs[i].exp_pulse);
      if (vecs[i].exp_pulse != 0) begin
        chk($sformatf("v%0d_type", i), last_word[69:68], vecs[i].exp_type);
        chk($sformatf("v%0d_hi_cnt", i), last_word[73:70], vecs[i].exp_hi);
        chk($sformatf("v%0d_word_tnum", i), last_word[67:44], 24'd1);
      end
    end
    accept_triggers = 1'b1; ttc_trigger = 1'b0; async_mode = 1'b1; ttc_acq_ready = 1'b1;
    chan_en = 5'b00001; burst_count = '0; fp_trig_width = 4'd0;

    // FIFO stall with timestamp restart and trig_num clear while the word waits
    do_reset();
    ready = 1'b0;
    tick();
    reset_trig_timestamp = 1'b1;
    tick();
    reset_trig_timestamp = 1'b0;
    repeat (3) tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    w0 = word_cnt;
    d0 = fifo_if.fifo_data;
    exp_word = {54'd0, 4'd1, 2'b00, 24'd1, 44'd3};
    chk("stall_word", d0, exp_word);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      reset_trig_num = (k == 2);
      tick();
      if (!fifo_if.fifo_valid || fifo_if.fifo_data !== d0) stable = 1'b0;
    end
    reset_trig_num = 1'b0;
    chk("stall_stable", stable, 1'b1);
    chk("stall_trig_num_cleared", trig_num, 24'd0);
    chk("stall_no_transfer", word_cnt - w0, 0);
    ready = 1'b1;
    repeat (10) tick();
    chk("stall_one_transfer", word_cnt - w0, 1);
    chk("stall_transfer_word", last_word, exp_word);

    // Holdoff veto
    do_reset();
    holdoff = 16'd20;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    n = 0;
    while (state != S_HOLD && n < 20) begin
      tick();
      n++;
    end
    chk("holdoff_entry", state, S_HOLD);
    p0 = pulse_cnt;
    for (int c = 0; c < 30; c++) begin
      if (c == 19) chk("holdoff_last_cycle", state, S_HOLD);
      if (c == 20) begin
        chk("holdoff_done", state, S_IDLE);
        chk("holdoff_veto", veto_count, 32'd1);
        chk("holdoff_no_pulse", pulse_cnt - p0, 0);
      end
      trigger = (c == 5 || c == 25);
      tick();
    end
    trigger = 1'b0;
    chk("holdoff_retrigger", pulse_cnt - p0, 1);
    holdoff = 16'd0;
    repeat (30) tick();

    // readout_done coincident with pulse_trigger
    do_reset();
    burst_count = {NCHAN{23'd3}};
    trigger = 1'b1;
    tick();
    chk("readout_pulse_seen", pulse_trigger, 1'b1);
    trigger = 1'b0;
    readout_done = 1'b1;
    tick();
    readout_done = 1'b0;
    chk("readout_stored", stored_bursts, '0);
    chk("readout_trig_num", trig_num, 24'd0);
    repeat (5) tick();

    // reset while STORE waits for the FIFO
    do_reset();
    ready = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("store_before_reset", state, S_STORE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_state", state, S_IDLE);
    chk("abort_fifo_valid", fifo_if.fifo_valid, 1'b0);
    ready = 1'b1;

    // DDR3 capacity on the relaxed-payload instance
    do_reset();
    chan_en = 5'b11111;
    burst_count = {NCHAN{23'h3FFFFF}};
    thres_overflow = 23'd100;
    p0 = cap_pulse_cnt;
    for (int t = 0; t < 2; t++) begin
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      repeat (5) tick();
    end
    trigger = 1'b1;
    repeat (50) tick();
    trigger = 1'b0;
    repeat (5) tick();
    chk("cap_pulses", cap_pulse_cnt - p0, 2);
    chk("cap_overflow", cap_ovf, 32'd1);
    chk("cap_stored4", cap_stored[4*SW +: SW], 24'h800000);
    chk("cap_stored0", cap_stored[SW-1:0], 24'h800000);
    chk("cap_almost_full", cap_afull, 1'b1);
    chk("cap_trig_num", cap_tnum, 24'd2);
    chk("cap_state", cap_state, S_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
